// File: rtl/mac_operand_sequencer.sv
// Operand/result sequencer around the combinational 3x3 matrix MAC: 32-bit operand words in, 32-bit result beats out.
// Optional feature macro MAC_REUSE_B_EN: adds reuse_b_i, which lets an operation skip LOAD_B and keep the previous matrix B.
module mac_operand_sequencer #(
   parameter int DATA_WIDTH = 72,
   parameter int MAT_SIZE   = 3,
   parameter int VAR_WIDTH  = 8,
   parameter int WORD_WIDTH = 32,
   parameter int BEATS      = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic [1:0]            op_i,
`ifdef MAC_REUSE_B_EN
   input  logic                  reuse_b_i,
`endif
   output logic                  busy_o,
   output logic                  err_o,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [WORD_WIDTH-1:0] in_data_i,
   output logic [DATA_WIDTH-1:0] matrixA_o,
   output logic [DATA_WIDTH-1:0] matrixB_o,
   output logic [1:0]            mac_op_o,
   input  logic [DATA_WIDTH-1:0] result_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [WORD_WIDTH-1:0] out_data_o,
   output logic                  out_last_o
);

   localparam int ELEMS = MAT_SIZE * MAT_SIZE;
   localparam int EPW   = WORD_WIDTH / VAR_WIDTH;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
   localparam logic [1:0]       OP_ILLEGAL = 2'b11;

   typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXEC, DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   mat_a_q, mat_a_d;
   logic [DATA_WIDTH-1:0]   mat_b_q, mat_b_d;
   logic [DATA_WIDTH-1:0]   result_q, result_d;
   logic [1:0]              op_q, op_d;
   logic                    busy_q, busy_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;
   logic                    err_q, err_d;
   logic                    reuse_b;
   logic                    in_fire;
   logic                    out_fire;

`ifdef MAC_REUSE_B_EN
   logic                    reuse_q, reuse_d;
   assign reuse_b = reuse_q;
`else
   assign reuse_b = 1'b0;
`endif

   // Element e sits at [DATA_WIDTH-1-VAR_WIDTH*e -: VAR_WIDTH]; beat n byte b carries element EPW*n+b.
   function automatic logic [DATA_WIDTH-1:0] write_beat(input logic [DATA_WIDTH-1:0] mat,
                                                        input logic [CNT_W-1:0]      beat,
                                                        input logic [WORD_WIDTH-1:0] word);
      logic [DATA_WIDTH-1:0] m;
      int                    e;
      m = mat;
      for (int b = 0; b < EPW; b++) begin
         e = int'(beat) * EPW + b;
         if (e < ELEMS) m[DATA_WIDTH-1-VAR_WIDTH*e -: VAR_WIDTH] = word[VAR_WIDTH*b +: VAR_WIDTH];
      end
      return m;
   endfunction

   function automatic logic [WORD_WIDTH-1:0] read_beat(input logic [DATA_WIDTH-1:0] mat,
                                                       input logic [CNT_W-1:0]      beat);
      logic [WORD_WIDTH-1:0] w;
      int                    e;
      w = '0;
      for (int b = 0; b < EPW; b++) begin
         e = int'(beat) * EPW + b;
         if (e < ELEMS) w[VAR_WIDTH*b +: VAR_WIDTH] = mat[DATA_WIDTH-1-VAR_WIDTH*e -: VAR_WIDTH];
      end
      return w;
   endfunction

   assign in_fire  = in_valid_i & in_ready_q;
   assign out_fire = out_valid_q & out_ready_i;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mat_a_d  = mat_a_q;
      mat_b_d  = mat_b_q;
      result_d = result_q;
      op_d     = op_q;
      err_d    = 1'b0;
`ifdef MAC_REUSE_B_EN
      reuse_d  = reuse_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (op_i == OP_ILLEGAL) begin
                  err_d = 1'b1;
               end else begin
                  op_d    = op_i;
                  cnt_d   = '0;
                  state_d = LOAD_A;
`ifdef MAC_REUSE_B_EN
                  reuse_d = reuse_b_i;
`endif
               end
            end
         end
         LOAD_A: begin
            if (in_fire) begin
               mat_a_d = write_beat(mat_a_q, cnt_q, in_data_i);
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  state_d = reuse_b ? EXEC : LOAD_B;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         LOAD_B: begin
            if (in_fire) begin
               mat_b_d = write_beat(mat_b_q, cnt_q, in_data_i);
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  state_d = EXEC;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         // The MAC has had a full cycle to settle on the held operands.
         EXEC: begin
            result_d = result_i;
            state_d  = DRAIN;
         end
         DRAIN: begin
            if (out_fire) begin
               if (cnt_q == LAST_BEAT) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      // Handshake/status outputs are registered from the next state so they track it exactly.
      busy_d      = (state_d != IDLE);
      in_ready_d  = (state_d == LOAD_A) || (state_d == LOAD_B);
      out_valid_d = (state_d == DRAIN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mat_a_q     <= '0;
         mat_b_q     <= '0;
         result_q    <= '0;
         op_q        <= 2'b00;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
`ifdef MAC_REUSE_B_EN
         reuse_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mat_a_q     <= mat_a_d;
         mat_b_q     <= mat_b_d;
         result_q    <= result_d;
         op_q        <= op_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
`ifdef MAC_REUSE_B_EN
         reuse_q     <= reuse_d;
`endif
      end
   end

   assign busy_o      = busy_q;
   assign err_o       = err_q;
   assign in_ready_o  = in_ready_q;
   assign matrixA_o   = mat_a_q;
   assign matrixB_o   = mat_b_q;
   assign mac_op_o    = op_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = read_beat(result_q, cnt_q);
   assign out_last_o  = out_valid_q & (cnt_q == LAST_BEAT);

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Self-checking bench for mac_operand_sequencer: a behavioural MAC drives result_i, an element-level model predicts result beats.
module tb_mac_operand_sequencer;

   logic        clk;
   logic        reset;
   logic        start_i;
   logic [1:0]  op_i;
`ifdef MAC_REUSE_B_EN
   logic        reuse_b_i;
`endif
   logic        busy_o;
   logic        err_o;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] in_data_i;
   logic [71:0] matrixA_o;
   logic [71:0] matrixB_o;
   logic [1:0]  mac_op_o;
   logic [71:0] result_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_data_o;
   logic        out_last_o;

   int          checks;
   int          errors;
   bit          rnd_gaps;
   logic [7:0]  ma [9];
   logic [7:0]  mb [9];
   logic [7:0]  model_b [9];
   logic [31:0] got_w [3];

   mac_operand_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .start_i    (start_i),
      .op_i       (op_i),
`ifdef MAC_REUSE_B_EN
      .reuse_b_i  (reuse_b_i),
`endif
      .busy_o     (busy_o),
      .err_o      (err_o),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .in_data_i  (in_data_i),
      .matrixA_o  (matrixA_o),
      .matrixB_o  (matrixB_o),
      .mac_op_o   (mac_op_o),
      .result_i   (result_i),
      .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i),
      .out_data_o (out_data_o),
      .out_last_o (out_last_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the combinational MAC unit.
   function automatic logic [71:0] mac_env(input logic [71:0] a, input logic [71:0] b, input logic [1:0] op);
      logic [71:0] r;
      logic [7:0]  acc;
      int          idx;
      r = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            idx = i * 3 + j;
            acc = 8'h00;
            case (op)
               2'b00: acc = a[71-8*idx -: 8] + b[71-8*idx -: 8];
               2'b01: acc = a[71-8*idx -: 8] - b[71-8*idx -: 8];
               2'b10: for (int k = 0; k < 3; k++) acc = acc + a[71-8*(i*3+k) -: 8] * b[71-8*(k*3+j) -: 8];
               default: acc = 8'h00;
            endcase
            r[71-8*idx -: 8] = acc;
         end
      end
      return r;
   endfunction

   always_comb result_i = mac_env(matrixA_o, matrixB_o, mac_op_o);

   function automatic logic [71:0] pack9(input logic [7:0] el [9]);
      return {el[0], el[1], el[2], el[3], el[4], el[5], el[6], el[7], el[8]};
   endfunction

   function automatic logic [31:0] beat_word(input logic [7:0] el [9], input int n, input bit dead);
      logic [23:0] upper;
      if (n == 0) return {el[3], el[2], el[1], el[0]};
      if (n == 1) return {el[7], el[6], el[5], el[4]};
      upper = dead ? 24'hDEAD00 : 24'($urandom);
      return {upper, el[8]};
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      int guard;
      if (rnd_gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      in_valid_i = 1'b1;
      in_data_i  = w;
      guard = 0;
      while (!in_ready_o && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk1("in_ready_timeout", guard < 20, 1'b1);
      @(negedge clk);
      in_valid_i = 1'b0;
      in_data_i  = $urandom;
   endtask

   task automatic check_all_zero(input string tag);
      chkw({tag, "_matA"}, matrixA_o, 72'h0);
      chkw({tag, "_matB"}, matrixB_o, 72'h0);
      chkw({tag, "_op"}, 72'(mac_op_o), 72'h0);
      chk1({tag, "_busy"}, busy_o, 1'b0);
      chk1({tag, "_err"}, err_o, 1'b0);
      chk1({tag, "_in_ready"}, in_ready_o, 1'b0);
      chk1({tag, "_out_valid"}, out_valid_o, 1'b0);
      chk1({tag, "_out_last"}, out_last_o, 1'b0);
      chkw({tag, "_out_data"}, 72'(out_data_o), 72'h0);
   endtask

   // One complete operation: start, load A (and B unless reused), then drain with optional stall.
   task automatic do_op(input logic [1:0] op, input bit reuse, input int stall_beat,
                        input int stall_len, input bit dead, input bit poke);
      logic [7:0]  res [9];
      logic [31:0] exp;
      int          r;
      int          c;
      int          sum;
      @(negedge clk);
      start_i = 1'b1;
      op_i    = op;
`ifdef MAC_REUSE_B_EN
      reuse_b_i = reuse;
`endif
      @(negedge clk);
      start_i = 1'b0;
      op_i    = 2'b00;
`ifdef MAC_REUSE_B_EN
      reuse_b_i = 1'b0;
`endif
      chk1("busy_after_start", busy_o, 1'b1);
      chkw("mac_op_latched", 72'(mac_op_o), 72'(op));
      for (int n = 0; n < 3; n++) begin
         if (poke && n == 1) begin
            start_i = 1'b1;
            op_i    = 2'b11;
            @(negedge clk);
            start_i = 1'b0;
            op_i    = 2'b00;
            chk1("start_while_busy_no_err", err_o, 1'b0);
         end
         send_word(beat_word(ma, n, dead));
      end
      chk1("in_ready_after_A", in_ready_o, !reuse);
      if (!reuse) begin
         for (int n = 0; n < 3; n++) send_word(beat_word(mb, n, dead));
         model_b = mb;
      end
      chk1("exec_no_valid", out_valid_o, 1'b0);
      @(negedge clk);
      chk1("drain_valid_latency", out_valid_o, 1'b1);
      chkw("matA_held", matrixA_o, pack9(ma));
      chkw("matB_held", matrixB_o, pack9(model_b));
      chkw("mac_op_held", 72'(mac_op_o), 72'(op));
      for (int e = 0; e < 9; e++) begin
         r = e / 3;
         c = e % 3;
         case (op)
            2'b00: sum = int'(ma[e]) + int'(model_b[e]);
            2'b01: sum = int'(ma[e]) - int'(model_b[e]);
            default: begin
               sum = 0;
               for (int k = 0; k < 3; k++) sum += int'(ma[r*3+k]) * int'(model_b[k*3+c]);
            end
         endcase
         res[e] = 8'(sum);
      end
      for (int n = 0; n < 3; n++) begin
         exp = (n == 2) ? {24'h0, res[8]} : beat_word(res, n, 1'b0);
         chk1("out_valid_beat", out_valid_o, 1'b1);
         chkw("out_data_beat", 72'(out_data_o), 72'(exp));
         chk1("out_last_beat", out_last_o, n == 2);
         got_w[n] = out_data_o;
         if (n == stall_beat) begin
            out_ready_i = 1'b0;
            repeat (stall_len) begin
               @(negedge clk);
               chk1("stall_valid", out_valid_o, 1'b1);
               chkw("stall_data_stable", 72'(out_data_o), 72'(exp));
               chk1("stall_last_stable", out_last_o, n == 2);
            end
            out_ready_i = 1'b1;
         end
         @(negedge clk);
      end
      chk1("busy_falls", busy_o, 1'b0);
      chk1("valid_falls", out_valid_o, 1'b0);
   endtask

   task automatic set_all(output logic [7:0] el [9], input logic [7:0] v);
      for (int e = 0; e < 9; e++) el[e] = v;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks      = 0;
      errors      = 0;
      rnd_gaps    = 1'b0;
      reset       = 1'b1;
      start_i     = 1'b0;
      op_i        = 2'b00;
`ifdef MAC_REUSE_B_EN
      reuse_b_i   = 1'b0;
`endif
      in_valid_i  = 1'b0;
      in_data_i   = '0;
      out_ready_i = 1'b1;
      for (int e = 0; e < 9; e++) model_b[e] = 8'h00;
      #1;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Add
      set_all(ma, 8'h01);
      set_all(mb, 8'h02);
      do_op(2'b00, 1'b0, -1, 0, 1'b0, 1'b1);
      chkw("add_w0", 72'(got_w[0]), 72'h03030303);
      chkw("add_w1", 72'(got_w[1]), 72'h03030303);
      chkw("add_w2", 72'(got_w[2]), 72'h00000003);

      // Subtract with wrap
      set_all(ma, 8'h00);
      set_all(mb, 8'h01);
      do_op(2'b01, 1'b0, -1, 0, 1'b0, 1'b0);
      chkw("sub_w0", 72'(got_w[0]), 72'hFFFFFFFF);
      chkw("sub_w2", 72'(got_w[2]), 72'h000000FF);

      // Multiply identity x (1..9), beat-2 upper bytes carry junk
      for (int e = 0; e < 9; e++) begin
         ma[e] = (e % 4 == 0) ? 8'h01 : 8'h00;
         mb[e] = 8'(e + 1);
      end
      do_op(2'b10, 1'b0, -1, 0, 1'b1, 1'b0);
      chkw("mul_w0", 72'(got_w[0]), 72'h04030201);
      chkw("mul_w1", 72'(got_w[1]), 72'h08070605);
      chkw("mul_w2", 72'(got_w[2]), 72'h00000009);

`ifdef MAC_REUSE_B_EN
      for (int e = 0; e < 9; e++) ma[e] = (e % 4 == 0) ? 8'h02 : 8'h00;
      do_op(2'b10, 1'b1, -1, 0, 1'b0, 1'b0);
      chkw("reuse_w0", 72'(got_w[0]), 72'h08060402);
      chkw("reuse_w1", 72'(got_w[1]), 72'h100E0C0A);
      chkw("reuse_w2", 72'(got_w[2]), 72'h00000012);
`endif

      // Backpressure: 5 stalled cycles on beat 1
      for (int e = 0; e < 9; e++) begin
         ma[e] = 8'($urandom);
         mb[e] = 8'($urandom);
      end
      do_op(2'b00, 1'b0, 1, 5, 1'b0, 1'b0);

      // Illegal opcode in IDLE
      @(negedge clk);
      start_i = 1'b1;
      op_i    = 2'b11;
      @(negedge clk);
      start_i = 1'b0;
      op_i    = 2'b00;
      chk1("illegal_err_pulse", err_o, 1'b1);
      chk1("illegal_busy", busy_o, 1'b0);
      @(negedge clk);
      chk1("illegal_err_one_cycle", err_o, 1'b0);
      chk1("illegal_busy_later", busy_o, 1'b0);
      chk1("illegal_no_ready", in_ready_o, 1'b0);

      // Reset after 4 of 6 operand beats
      @(negedge clk);
      start_i = 1'b1;
      op_i    = 2'b01;
      @(negedge clk);
      start_i = 1'b0;
      op_i    = 2'b00;
      for (int n = 0; n < 3; n++) send_word(beat_word(ma, n, 1'b0));
      send_word(beat_word(mb, 0, 1'b0));
      reset = 1'b1;
      #1;
      check_all_zero("midreset");
      @(negedge clk);
      reset = 1'b0;
      for (int e = 0; e < 9; e++) model_b[e] = 8'h00;

`ifdef MAC_REUSE_B_EN
      for (int e = 0; e < 9; e++) ma[e] = (e % 4 == 0) ? 8'h02 : 8'h00;
      do_op(2'b10, 1'b1, -1, 0, 1'b0, 1'b0);
      chkw("reuse_after_reset_w0", 72'(got_w[0]), 72'h0);
`endif
      for (int e = 0; e < 9; e++) begin
         ma[e] = 8'(e * 7 + 3);
         mb[e] = 8'(250 - e);
      end
      do_op(2'b10, 1'b0, -1, 0, 1'b0, 1'b0);

      // Randomized operations with input gaps and output stalls
      rnd_gaps = 1'b1;
      for (int t = 0; t < 8; t++) begin
         for (int e = 0; e < 9; e++) begin
            ma[e] = 8'($urandom);
            mb[e] = 8'($urandom);
         end
`ifdef MAC_REUSE_B_EN
         do_op(2'($urandom_range(0, 2)), t[0], $urandom_range(0, 2), $urandom_range(1, 4), 1'b0, t == 2);
`else
         do_op(2'($urandom_range(0, 2)), 1'b0, $urandom_range(0, 2), $urandom_range(1, 4), 1'b0, t == 2);
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
